// File: rtl/clk_gate_active_ctrl.sv
// clk_gate_active_ctrl
//
// Activity controller for a downstream gated clock domain. It runs on the free-running
// clock and watches request and busy traffic. It drops the clock-enable level after a
// programmable number of consecutive idle cycles. On new work it raises the enable again,
// but keeps req_ready low until the gated clock is known to be running.
//
// Parameters:
//   CNT_W       width of the idle counter and idle_thresh
//   WAKE_CYCLES cycles from active rising to req_ready rising (1..255)
//   RST_ACTIVE  1: reset into RUN (clock on), 0: reset into OFF (clock gated)
//
// Ports:
//   clk          free-running clock
//   rst_n        synchronous active-low reset
//   req_valid    request for the gated domain, held until accepted
//   req_ready    request accepted when req_valid && req_ready (registered)
//   busy         gated domain still has work in flight
//   force_on     software override, keeps or brings the clock on
//   idle_thresh  consecutive idle cycles before gating, 0 disables auto-gating
//   active       clock-enable level to en_as_clk_gating (registered)
//   gated        status, high while the clock is gated (registered)
//   gate_events  count of RUN->OFF transitions
//
// Optional feature macro: CLK_GATE_STAT_EN. When it is defined, gate_events is a saturating
// 16-bit counter that only reset clears. When it is undefined, gate_events is tied to zero
// and no counter flops exist.

module clk_gate_active_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WAKE_CYCLES = 3,
  parameter int unsigned RST_ACTIVE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             busy,
  input  logic             force_on,
  input  logic [CNT_W-1:0] idle_thresh,
  output logic             active,
  output logic             gated,
  output logic [15:0]      gate_events
);

  typedef enum logic [1:0] {StRun, StOff, StWake} state_e;

  localparam state_e           RstState  = (RST_ACTIVE != 0) ? StRun : StOff;
  localparam logic             RstActive = (RST_ACTIVE != 0);
  localparam logic [7:0]       WakeLast  = 8'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]       wake_cnt_q, wake_cnt_d;
  logic             active_q, active_d;
  logic             req_ready_q, req_ready_d;
  logic             gated_q, gated_d;
  logic             gate_evt;

  logic             wake_cond;
  logic             idle_cyc;
  logic [CNT_W:0]   cnt_inc;
  logic             thresh_hit;

  assign wake_cond = req_valid | busy | force_on;
  assign idle_cyc  = ~wake_cond;

  // One extra bit so a saturated counter still compares correctly against any threshold.
  assign cnt_inc    = {1'b0, idle_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign thresh_hit = (idle_thresh != '0) && (cnt_inc >= {1'b0, idle_thresh});

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    gate_evt   = 1'b0;

    unique case (state_q)
      StRun: begin
        if (!idle_cyc) begin
          idle_cnt_d = '0;
        end else if (thresh_hit) begin
          state_d    = StOff;
          idle_cnt_d = '0;
          gate_evt   = 1'b1;
        end else if (idle_cnt_q != CntMax) begin
          idle_cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      StOff: begin
        if (wake_cond) begin
          state_d    = StWake;
          wake_cnt_d = '0;
        end
      end
      StWake: begin
        // Never aborted: the wake-up always completes so the gated clock is running.
        if (wake_cnt_q == WakeLast) begin
          state_d    = StRun;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = RstState;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    active_d    = (state_d != StOff);
    req_ready_d = (state_d == StRun);
    gated_d     = (state_d == StOff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RstState;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      active_q    <= RstActive;
      req_ready_q <= RstActive;
      gated_q     <= ~RstActive;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      active_q    <= active_d;
      req_ready_q <= req_ready_d;
      gated_q     <= gated_d;
    end
  end

  assign active    = active_q;
  assign req_ready = req_ready_q;
  assign gated     = gated_q;

`ifdef CLK_GATE_STAT_EN
  logic [15:0] gate_events_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_events_q <= 16'h0;
    end else if (gate_evt && (gate_events_q != 16'hFFFF)) begin
      gate_events_q <= gate_events_q + 16'd1;
    end
  end

  assign gate_events = gate_events_q;
`else
  logic unused_gate_evt;
  assign unused_gate_evt = gate_evt;
  assign gate_events     = 16'h0;
`endif

endmodule

// File: tb/tb_clk_gate_active_ctrl.sv
module tb_clk_gate_active_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       busy;
  logic       force_on;
  logic [7:0] idle_thresh;
  logic       active;
  logic       gated;
  logic [15:0] gate_events;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: clock on/off, ready flag, idle run length, remaining wake cycles.
  bit m_on;
  bit m_ready;
  int m_idle;
  int m_wake_left;
  int m_events;

  localparam int Wake = 3;

  clk_gate_active_ctrl #(
    .CNT_W      (8),
    .WAKE_CYCLES(Wake),
    .RST_ACTIVE (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .busy       (busy),
    .force_on   (force_on),
    .idle_thresh(idle_thresh),
    .active     (active),
    .gated      (gated),
    .gate_events(gate_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       rv;
    logic       b;
    logic       fo;
    logic [7:0] th;
    logic       ea;
    logic       er;
    logic       eg;
  } vec_t;

  vec_t tbl[27];

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_on = 1; m_ready = 1; m_idle = 0; m_wake_left = 0; m_events = 0;
    end else if (m_on && m_ready) begin
      if (req_valid || busy || force_on) m_idle = 0;
      else if (idle_thresh != 0 && m_idle + 1 >= int'(idle_thresh)) begin
        m_on = 0; m_ready = 0; m_idle = 0;
        if (m_events < 65535) m_events++;
      end else if (m_idle < 255) m_idle++;
    end else if (!m_on) begin
      if (req_valid || busy || force_on) begin
        m_on = 1; m_wake_left = Wake;
      end
    end else begin
      m_wake_left--;
      if (m_wake_left == 0) m_ready = 1;
    end
  endtask

  function automatic int exp_events();
`ifdef CLK_GATE_STAT_EN
    return m_events;
`else
    return 0;
`endif
  endfunction

  task automatic step(input logic r, input logic rv, input logic b, input logic fo,
                      input logic [7:0] th);
    rst_n = r; req_valid = rv; busy = b; force_on = fo; idle_thresh = th;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(input string nm);
    cmp({nm, "_active"}, 32'(active), 32'(m_on));
    cmp({nm, "_ready"}, 32'(req_ready), 32'(m_on && m_ready));
    cmp({nm, "_gated"}, 32'(gated), 32'(!m_on));
    cmp({nm, "_events"}, 32'(gate_events), exp_events());
  endtask

  initial begin
    bit all_on;
    rst_n = 1'b0; req_valid = 1'b0; busy = 1'b0; force_on = 1'b0; idle_thresh = 8'd4;
    m_on = 1; m_ready = 1; m_idle = 0; m_wake_left = 0; m_events = 0;

    //          r  rv b  fo th    a  rdy g
    tbl[0]  = '{0, 0, 0, 0, 4,    1, 1, 0};
    tbl[1]  = '{1, 0, 0, 0, 4,    1, 1, 0};
    tbl[2]  = '{1, 0, 0, 0, 4,    1, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 4,    1, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, 4,    0, 0, 1};
    tbl[5]  = '{1, 0, 0, 0, 4,    0, 0, 1};
    tbl[6]  = '{1, 1, 0, 0, 4,    1, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 4,    1, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 4,    1, 0, 0};
    tbl[9]  = '{1, 1, 0, 0, 4,    1, 1, 0};
    tbl[10] = '{1, 1, 0, 0, 4,    1, 1, 0};
    tbl[11] = '{1, 0, 0, 0, 4,    1, 1, 0};
    tbl[12] = '{1, 0, 0, 0, 4,    1, 1, 0};
    tbl[13] = '{1, 0, 0, 0, 4,    1, 1, 0};
    tbl[14] = '{1, 0, 0, 0, 4,    0, 0, 1};
    tbl[15] = '{1, 0, 0, 1, 4,    1, 0, 0};
    tbl[16] = '{1, 0, 0, 0, 4,    1, 0, 0};
    tbl[17] = '{1, 0, 0, 0, 4,    1, 0, 0};
    tbl[18] = '{1, 0, 0, 0, 4,    1, 1, 0};
    tbl[19] = '{1, 0, 0, 0, 4,    1, 1, 0};
    tbl[20] = '{1, 0, 0, 0, 4,    1, 1, 0};
    tbl[21] = '{1, 0, 0, 0, 4,    1, 1, 0};
    tbl[22] = '{1, 0, 0, 0, 4,    0, 0, 1};
    tbl[23] = '{1, 0, 1, 0, 4,    1, 0, 0};
    tbl[24] = '{0, 0, 0, 0, 4,    1, 1, 0};
    tbl[25] = '{1, 0, 1, 0, 1,    1, 1, 0};
    tbl[26] = '{1, 0, 0, 0, 1,    0, 0, 1};

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].r, tbl[i].rv, tbl[i].b, tbl[i].fo, tbl[i].th);
      cmp($sformatf("tbl%0d_active", i), 32'(active), 32'(tbl[i].ea));
      cmp($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].er));
      cmp($sformatf("tbl%0d_gated", i), 32'(gated), 32'(tbl[i].eg));
      cmp($sformatf("tbl%0d_events", i), 32'(gate_events), exp_events());
    end

    // Busy every third cycle keeps the idle run below the threshold.
    step(0, 0, 0, 0, 4);
    all_on = 1;
    for (int i = 0; i < 30; i++) begin
      step(1, 0, (i % 3) == 0, 0, 4);
      check_model("busy3");
      if (!active) all_on = 0;
    end
    cmp("busy3_stays_on", 32'(all_on), 32'd1);

    // Auto-gating disabled, then a low threshold against a saturated counter.
    for (int i = 0; i < 1000; i++) begin
      step(1, 0, 0, 0, 0);
      if (i % 50 == 0) check_model("thr0");
    end
    cmp("thr0_active", 32'(active), 32'd1);
    step(1, 0, 0, 0, 2);
    cmp("sat_gate_active", 32'(active), 32'd0);
    check_model("sat_gate");

    // Five gate/wake sequences from a fresh reset.
    step(0, 0, 0, 0, 2);
    for (int s = 0; s < 5; s++) begin
      step(1, 0, 0, 0, 2);
      step(1, 0, 0, 0, 2);
      check_model("seq_gate");
      step(1, 0, 0, 1, 2);
      for (int j = 0; j < Wake; j++) step(1, 0, 0, 0, 2);
      check_model("seq_wake");
    end
`ifdef CLK_GATE_STAT_EN
    cmp("five_events", 32'(gate_events), 32'd5);
`else
    cmp("five_events", 32'(gate_events), 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 15) == 0, 8'($urandom_range(0, 6)));
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_gate_active_ctrl.md
# clk_gate_active_ctrl

Activity controller that decides when a downstream clock domain may be gated. It watches request and busy traffic in the free-running clock domain and drives the `active` level consumed by `en_as_clk_gating` (`active` port). It gates after a programmable number of consecutive idle cycles and re-enables on new work. During wake-up it holds off new requests until the gated clock is known to be running, covering the 2-stage synchroniser and gating-cell latency downstream.

## Interface
Parameters:
- `CNT_W`, 8: width of the idle counter and `idle_thresh`.
- `WAKE_CYCLES`, 3: cycles between `active` rising and `req_ready` rising. Legal range 1..255; default covers the 2-stage sync plus 1 gating cycle.
- `RST_ACTIVE`, 1: 1 = reset into RUN (clock on); 0 = reset into OFF (clock gated).

Ports:
- `clk`  in  1  free-running clock (same clock as downstream `raw_clk`).
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  new request for the gated domain; held until accepted.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`; registered.
- `busy`  in  1  gated domain still has work in flight (level).
- `force_on`  in  1  software override; keeps or brings the clock on.
- `idle_thresh`  in  CNT_W  consecutive idle cycles before gating; 0 disables auto-gating.
- `active`  out  1  clock-enable level to `en_as_clk_gating`; registered.
- `gated`  out  1  status, 1 while in OFF; registered.
- `gate_events`  out  16  gating-event count (see Configuration).

## Operation
- Idle cycle: `!req_valid && !busy && !force_on`.
- Wake condition: `req_valid || busy || force_on`.
- Three-state FSM:
  - RUN: `active=1`, `req_ready=1`, `gated=0`.
    - Idle counter increments on each idle cycle and saturates at 2^CNT_W-1. It clears on any non-idle cycle.
    - On an idle cycle where `idle_thresh!=0` and `cnt+1 >= idle_thresh`, go to OFF and clear the counter.
  - OFF: `active=0`, `req_ready=0`, `gated=1`.
    - On the wake condition, go to WAKE and load the wake counter with 0.
  - WAKE: `active=1`, `req_ready=0`, `gated=0`.
    - Wake counter increments each cycle. When it reaches `WAKE_CYCLES-1`, go to RUN.
    - WAKE is never aborted: if the wake condition drops, the FSM still completes to RUN.
- `idle_thresh` is sampled every cycle. Lowering it below the current count gates on the next idle cycle.
- Simultaneous wake condition and threshold hit in RUN: the cycle is non-idle, so the FSM stays in RUN.
- Any `rst_n=0` cycle, from any state, forces the reset state at the next edge. Both counters clear.
- Reset values:
  - `RST_ACTIVE=1`: state RUN, `active=1`, `req_ready=1`, `gated=0`.
  - `RST_ACTIVE=0`: state OFF, `active=0`, `req_ready=0`, `gated=1`.
  - `gate_events=0` in both cases.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Gating latency: with `idle_thresh=N` and idle cycles starting at edge k, `active` falls after edge k+N-1, i.e. N idle samples.
- Wake latency: wake condition sampled in OFF at edge k gives `active=1` after edge k and `req_ready=1` after edge k+WAKE_CYCLES.
- The first request transfer occurs at edge k+WAKE_CYCLES+1 at the earliest.
- `req_valid` held in RUN is accepted in the same cycle (`req_ready` already 1). An accepted request is a non-idle cycle.

## Configuration
- `CLK_GATE_STAT_EN` defined:
  - `gate_events` increments by 1 on every RUN->OFF transition and saturates at 16'hFFFF.
  - It clears on reset only.
- Not defined: `gate_events` is tied to 16'h0 and no counter flops are instantiated.

## Test plan
- Reset with `RST_ACTIVE=1`, `idle_thresh=4`, all inputs 0 -> `active=1` for 4 cycles after reset release, 0 from the 5th; `gated=1`.
- OFF, pulse `req_valid` held high, `WAKE_CYCLES=3` -> `active=1` next cycle, `req_ready=1` exactly 3 cycles later, transfer on the following edge, return to OFF 4 idle cycles after `req_valid` drops.
- RUN with `idle_thresh=4`, `busy` toggles 1 every 3rd cycle -> counter never reaches 4, `active` stays 1.
- `idle_thresh=0`, 1000 idle cycles -> `active` stays 1. Then `idle_thresh=2` with the counter saturated at 255 -> gate after the next idle cycle.
- WAKE entered by `force_on` for 1 cycle, then all inputs 0 -> WAKE completes to RUN, then gates after `idle_thresh` cycles. `rst_n=0` mid-WAKE -> reset state next edge.
- `CLK_GATE_STAT_EN` defined, 5 gate/wake sequences -> `gate_events=5`. Macro undefined -> `gate_events=0` throughout.
